// File: rtl/instr_mem_loader_if.sv
// Loader command/stream/write-port bundle; master = boot host side, slave = loader.
interface instr_mem_loader_if #(
    parameter int NUM_BANKS     = 3,
    parameter int SIZE_BANKI    = 32,
    parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI),
    parameter int BANK_W        = (NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1)
);
    logic                     start;
    logic [BANK_W-1:0]        bank_sel;
    logic                     broadcast;
    logic [SHIRINA_BANKI:0]   word_count;
    logic                     abort;
    logic                     in_valid;
    logic [31:0]              in_data;
    logic                     in_ready;
    logic [NUM_BANKS-1:0]     we;
    logic [SHIRINA_BANKI-1:0] wa;
    logic [31:0]              wd;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [31:0]              checksum;

    modport master (
        output start, bank_sel, broadcast, word_count, abort, in_valid, in_data,
        input  in_ready, we, wa, wd, busy, done, error, checksum
    );
    modport slave (
        input  start, bank_sel, broadcast, word_count, abort, in_valid, in_data,
        output in_ready, we, wa, wd, busy, done, error, checksum
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams 32-bit words into one instruction bank (or all banks) at sequential addresses.
// Build option LOADER_CHECKSUM_EN adds a running XOR of accepted words on checksum.
module instr_mem_loader #(
    parameter int NUM_BANKS     = 3,
    parameter int SIZE_BANKI    = 32,
    parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI),
    parameter int BANK_W        = (NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1)
) (
    input logic              clk,
    input logic              rst_n,
    instr_mem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t                   state_q, state_d;
    logic [NUM_BANKS-1:0]     mask_q, mask_d;
    logic [SHIRINA_BANKI:0]   cnt_q, cnt_d;
    logic [SHIRINA_BANKI-1:0] addr_q, addr_d;
    logic [NUM_BANKS-1:0]     we_q, we_d;
    logic [SHIRINA_BANKI-1:0] wa_q, wa_d;
    logic [31:0]              wd_q, wd_d;
    logic                     err_q, err_d;
    logic                     cmd_ok, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]              cs_q, cs_d;
`endif

    assign cmd_ok = (bus.word_count != '0) && (32'(bus.word_count) <= SIZE_BANKI) &&
                    (bus.broadcast || (32'(bus.bank_sel) < NUM_BANKS));
    // addr_q counts words already written, so this handshake is the last one
    assign last_word = ({1'b0, addr_q} + (SHIRINA_BANKI+1)'(1)) == cnt_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = '0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        cs_d    = cs_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                if (cmd_ok) begin
                    mask_d  = bus.broadcast ? '1 : (NUM_BANKS'(1) << bus.bank_sel);
                    cnt_d   = bus.word_count;
                    addr_d  = '0;
                    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    cs_d    = '0;
`endif
                    state_d = LOAD;
                end else begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                // abort wins over a same-cycle handshake: that word is dropped
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    we_d   = mask_q;
                    wa_d   = addr_q;
                    wd_d   = bus.in_data;
                    addr_d = addr_q + SHIRINA_BANKI'(1);
`ifdef LOADER_CHECKSUM_EN
                    cs_d   = cs_q ^ bus.in_data;
`endif
                    if (last_word) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cs_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            cs_q    <= cs_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.error    = err_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus.checksum = cs_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized + directed bench for instr_mem_loader against a transaction-level reference model.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if bus ();
    instr_mem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // reference model: load in progress, pending FIN cycle, words left, next address
    bit          m_act, m_fin, m_err;
    int          m_left, m_addr;
    logic [2:0]  m_mask, e_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_cs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_fin = 0; m_err = 0; m_left = 0; m_addr = 0;
        m_mask = 0; e_we = 0; m_wa = 0; m_wd = 0; m_cs = 0;
    endtask

    task automatic model_step(input bit st, input int bs, input bit bc, input int wc,
                              input bit ab, input bit v, input logic [31:0] d);
        e_we = 3'b000;
        if (m_act) begin
            if (ab) m_act = 0;
            else if (v) begin
                e_we = m_mask; m_wa = 5'(m_addr); m_wd = d; m_cs ^= d;
                m_addr++; m_left--;
                if (m_left == 0) begin m_act = 0; m_fin = 1; end
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (st) begin
            if (wc >= 1 && wc <= 32 && (bc || bs < 3)) begin
                m_act = 1; m_left = wc; m_addr = 0; m_err = 0; m_cs = 0;
                m_mask = bc ? 3'b111 : 3'(1 << bs);
            end else m_err = 1;
        end
    endtask

    task automatic check_all();
        chk("we", 32'(bus.we), 32'(e_we));
        chk("wa", 32'(bus.wa), 32'(m_wa));
        chk("wd", bus.wd, m_wd);
        chk("done", 32'(bus.done), 32'(m_fin));
        chk("busy", 32'(bus.busy), 32'(m_act | m_fin));
        chk("in_ready", 32'(bus.in_ready), 32'(m_act));
        chk("error", 32'(bus.error), 32'(m_err));
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", bus.checksum, m_cs);
`else
        chk("checksum", bus.checksum, 32'h0);
`endif
    endtask

    task automatic cyc(input bit st, input int bs, input bit bc, input int wc,
                       input bit ab, input bit v, input logic [31:0] d);
        bus.start = st; bus.bank_sel = 2'(bs); bus.broadcast = bc; bus.word_count = 6'(wc);
        bus.abort = ab; bus.in_valid = v; bus.in_data = d;
        model_step(st, bs, bc, wc, ab, v, d);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        bus.start = 0; bus.bank_sel = 0; bus.broadcast = 0; bus.word_count = 0;
        bus.abort = 0; bus.in_valid = 0; bus.in_data = 0;
        model_reset();
        #2; check_all();
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);

        // single bank, back-to-back stream
        cyc(1, 1, 0, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h11);
        cyc(0, 0, 0, 0, 0, 1, 32'h22);
        cyc(0, 0, 0, 0, 0, 1, 32'h33);
        cyc(0, 0, 0, 0, 0, 1, 32'h44);
        chk("t1_done_last", {31'h0, bus.done}, 32'h1);
        chk("t1_wa_last", 32'(bus.wa), 32'd3);
        idle(2);

        // broadcast with a gap in the stream
        cyc(1, 2, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hCAFE0001);
        cyc(0, 0, 0, 0, 0, 0, 32'hDEAD0000);
        cyc(0, 0, 0, 0, 0, 1, 32'hCAFE0002);
        chk("t2_we_bcast", 32'(bus.we), 32'h7);
        idle(2);

        // rejected commands, then a valid one clears error
        cyc(1, 3, 0, 4, 0, 1, 32'h1);  idle(1);
        chk("t3_err_bank", {31'h0, bus.error}, 32'h1);
        cyc(1, 0, 0, 0, 0, 1, 32'h2);  idle(1);
        cyc(1, 0, 0, 33, 0, 1, 32'h3); idle(1);
        chk("t3_err_wc33", {31'h0, bus.error}, 32'h1);
        cyc(1, 2, 0, 1, 0, 0, 0);
        chk("t3_err_clr", {31'h0, bus.error}, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h77);
        idle(2);

        // abort after two of five, with a word offered in the abort cycle
        cyc(1, 2, 0, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hA1);
        cyc(0, 0, 0, 0, 0, 1, 32'hA2);
        cyc(0, 0, 0, 0, 1, 1, 32'hA3);
        chk("t4_no_write", 32'(bus.we), 32'h0);
        idle(3);

        // full bank with a stray start in the middle
        cyc(1, 0, 0, 32, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            cyc(i == 10, 1, 1, 3, 0, 1, $urandom);
        chk("t5_wa_max", 32'(bus.wa), 32'd31);
        idle(2);

        // checksum pattern
        cyc(1, 0, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
        cyc(0, 0, 0, 0, 0, 1, 32'h0F0F0F0F);
        idle(2);
`ifdef LOADER_CHECKSUM_EN
        chk("t6_cs", bus.checksum, 32'hAAAAAAAA);
`else
        chk("t6_cs", bus.checksum, 32'h0);
`endif

        // randomized transactions
        for (int t = 0; t < 30; t++) begin
            int wc;
            wc = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 33)
                                             : int'($urandom_range(1, 12));
            cyc(1, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, wc, 0, 0, 0);
            for (int k = 0; k < 200 && (m_act || m_fin); k++)
                cyc($urandom_range(0, 15) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 1),
                    int'($urandom_range(0, 33)), $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0, $urandom);
            if (m_act || m_fin) chk("rand_timeout", 32'd1, 32'd0);
            idle(int'($urandom_range(0, 2)));
        end

        // asynchronous reset in the middle of a load
        cyc(1, 1, 0, 6, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h5);
        cyc(0, 0, 0, 0, 0, 1, 32'h6);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
